usb_ls_bus_monitor: RTL

- Passive low-speed (1.5 Mbps) USB line monitor for the simulation top-level.
- Taps the resolved D+/D- of one port, after pull-up/pull-down emulation between the USB HID host and the emulated device.
- Recovers bit timing, NRZI-decodes, unstuffs, frames packets and emits a byte stream with per-packet status for scoreboards and trace dumps.
- Never drives the bus.

---
 rtl/usb_mon_pkg.sv | 23 ++
 rtl/usb_ls_bit_recovery.sv | 34 +++
 rtl/usb_ls_bus_monitor.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/usb_mon_pkg.sv
// usb_mon_pkg: shared types, PIDs, CRC constants and status bit indices for the low-speed USB line monitor.
package usb_mon_pkg;
  typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} mon_state_t;
  localparam logic [7:0] PID_ACK = 8'hD2;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_IN = 8'h69;
  localparam logic [4:0] CRC5_POLY = 5'h05;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam int ST_PID = 0;
  localparam int ST_STUFF = 1;
  localparam int ST_ALIGN = 2;
  localparam int ST_CRC = 3;
  localparam int ST_SYNC = 4;
  localparam int ST_SE1 = 5;
  // low-speed polarity: J idles with D- high
  function automatic line_state_t decode_ls(input logic dp, input logic dm);
    return dp ? (dm ? SE1 : K) : (dm ? J : SE0);
  endfunction
endpackage

// File: rtl/usb_ls_bit_recovery.sv
// usb_ls_bit_recovery: synchronizes D+/D-, decodes the line state and strobes once per bit at mid-bit.
module usb_ls_bit_recovery
  import usb_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        dp_i,
  input  logic        dm_i,
  output logic        strobe,
  output line_state_t line
);
  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] HALF = PW'(CLKS_PER_BIT / 2);
  logic [1:0] dp_s, dm_s;
  logic [PW-1:0] phase;
  line_state_t ls;
  assign ls = decode_ls(dp_s[1], dm_s[1]);
  assign strobe = phase == HALF;
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      dp_s <= 2'b00;
      dm_s <= 2'b11;
      line <= J;
      phase <= '0;
    end else begin
      dp_s <= {dp_s[0], dp_i};
      dm_s <= {dm_s[0], dm_i};
      line <= ls;
      phase <= (ls != line || phase == LAST) ? '0 : phase + 1'b1;
    end
endmodule

// File: rtl/usb_ls_bus_monitor.sv
// usb_ls_bus_monitor: passive low-speed USB decoder producing bytes, per-packet status and bus events.
// Define USB_MON_CRC_EN to add CRC5/CRC16 checking; otherwise crc_err stays 0.
module usb_ls_bus_monitor
  import usb_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int RESET_BITS = 16,
  parameter int IDLE_BITS = 7
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        dp_i,
  input  logic        dm_i,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic [5:0]  rx_status,
  output logic        keepalive,
  output logic        bus_reset,
  output logic [15:0] pkt_count
);
  localparam int SW = $clog2(RESET_BITS + 1);
  localparam int JW = $clog2(IDLE_BITS + 1);
  localparam logic [SW-1:0] RST_MAX = SW'(RESET_BITS);
  localparam logic [SW-1:0] RST_LAST = SW'(RESET_BITS - 1);
  localparam logic [SW-1:0] KA_MAX = SW'(3);
  localparam logic [JW-1:0] IDLE_LAST = JW'(IDLE_BITS - 1);
  logic strobe, nrzi, crc_bad;
  line_state_t line, prev;
  mon_state_t state, state_nx;
  logic [5:0] flags, flags_nx, err_set;
  logic [7:0] shift, shift_nx;
  logic [2:0] bit_cnt, bit_cnt_nx, zeros, zeros_nx, ones, ones_nx;
  logic first, first_nx, valid_nx, sop_nx, eop_nx, ka_nx, br_nx;
  logic [SW-1:0] se0_cnt, se0_cnt_nx;
  logic [JW-1:0] j_cnt, j_cnt_nx;
  usb_ls_bit_recovery #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rec (
    .clk(clk), .rst_ni(rst_ni), .dp_i(dp_i), .dm_i(dm_i), .strobe(strobe), .line(line)
  );
  assign nrzi = line == prev;
`ifdef USB_MON_CRC_EN
  logic [4:0] crc5;
  logic [15:0] crc16;
  logic [1:0] kind;
  logic kept;
  assign kept = strobe && state == DATA && (line == J || line == K) && ones != 3'd6;
  // the PID byte reseeds the CRCs; kind latches pid[1:0] on its last bit
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      crc5 <= '1;
      crc16 <= '1;
      kind <= '0;
    end else if (kept && first) begin
      crc5 <= '1;
      crc16 <= '1;
      kind <= shift[2:1];
    end else if (kept) begin
      crc5 <= {crc5[3:0], 1'b0} ^ ({5{nrzi ^ crc5[4]}} & CRC5_POLY);
      crc16 <= {crc16[14:0], 1'b0} ^ ({16{nrzi ^ crc16[15]}} & CRC16_POLY);
    end
  assign crc_bad = !first && (kind == 2'b01 ? crc5 != CRC5_RESIDUAL : kind == 2'b11 && crc16 != CRC16_RESIDUAL);
`else
  assign crc_bad = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    flags_nx = flags;
    shift_nx = shift;
    bit_cnt_nx = bit_cnt;
    zeros_nx = zeros;
    ones_nx = ones;
    first_nx = first;
    se0_cnt_nx = se0_cnt;
    j_cnt_nx = j_cnt;
    err_set = '0;
    valid_nx = 1'b0;
    sop_nx = 1'b0;
    eop_nx = 1'b0;
    ka_nx = 1'b0;
    br_nx = 1'b0;
    if (strobe) begin
      if (line == SE1 && state != ERR) err_set[ST_SE1] = 1'b1;
      else case (state)
        IDLE: begin
          se0_cnt_nx = line != SE0 ? '0 : se0_cnt == RST_MAX ? se0_cnt : se0_cnt + 1'b1;
          br_nx = line == SE0 && se0_cnt == RST_LAST;
          ka_nx = line == J && se0_cnt != '0 && se0_cnt <= KA_MAX;
          if (line == K) begin
            state_nx = SYNC;
            zeros_nx = 3'd1;
          end
        end
        SYNC:
          if (line == SE0 || (nrzi && zeros < 3'd5)) err_set[ST_SYNC] = 1'b1;
          else if (!nrzi) zeros_nx = zeros == 3'd7 ? zeros : zeros + 3'd1;
          else begin
            state_nx = DATA;
            ones_nx = 3'd1;
            bit_cnt_nx = '0;
            first_nx = 1'b1;
          end
        DATA:
          if (line == SE0) begin
            state_nx = EOP;
            flags_nx[ST_ALIGN] = flags[ST_ALIGN] | (bit_cnt != '0);
            flags_nx[ST_CRC] = crc_bad;
          end else if (ones == 3'd6) begin
            err_set[ST_STUFF] = nrzi;
            ones_nx = '0;
          end else begin
            shift_nx = {nrzi, shift[7:1]};
            bit_cnt_nx = bit_cnt + 3'd1;
            ones_nx = nrzi ? ones + 3'd1 : '0;
            if (bit_cnt == 3'd7) begin
              valid_nx = 1'b1;
              sop_nx = first;
              first_nx = 1'b0;
              if (first) flags_nx[ST_PID] = shift_nx[7:4] != ~shift_nx[3:0];
            end
          end
        EOP:
          if (line == J) begin
            state_nx = IDLE;
            eop_nx = 1'b1;
          end else if (line == K) err_set[ST_SE1] = 1'b1;
        ERR: begin
          j_cnt_nx = line == J ? j_cnt + 1'b1 : '0;
          if (line == J && j_cnt == IDLE_LAST) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
      if (|err_set) begin
        state_nx = ERR;
        flags_nx = flags_nx | err_set;
        eop_nx = 1'b1;
        j_cnt_nx = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      prev <= J;
      flags <= '0;
      shift <= '0;
      bit_cnt <= '0;
      zeros <= '0;
      ones <= '0;
      first <= 1'b0;
      se0_cnt <= '0;
      j_cnt <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_sop <= 1'b0;
      rx_eop <= 1'b0;
      rx_status <= '0;
      keepalive <= 1'b0;
      bus_reset <= 1'b0;
      pkt_count <= '0;
    end else begin
      state <= state_nx;
      if (strobe) prev <= line;
      flags <= state_nx == IDLE ? '0 : flags_nx;
      shift <= shift_nx;
      bit_cnt <= bit_cnt_nx;
      zeros <= zeros_nx;
      ones <= ones_nx;
      first <= first_nx;
      se0_cnt <= state_nx == IDLE ? se0_cnt_nx : '0;
      j_cnt <= j_cnt_nx;
      rx_valid <= valid_nx;
      rx_sop <= sop_nx;
      if (valid_nx) rx_data <= shift_nx;
      rx_eop <= eop_nx;
      if (eop_nx) rx_status <= flags_nx;
      keepalive <= ka_nx;
      bus_reset <= br_nx;
      if (eop_nx && flags_nx == '0) pkt_count <= pkt_count + 16'd1;
    end
endmodule
